// File: rtl/register_write_arbiter.sv
// register_write_arbiter
//   Round-robin arbiter sharing one W-bit Register among N requesters.
//   Each transaction walks IDLE -> LOAD -> DONE: the winner's data is latched
//   in IDLE, driven to the Register with a one-cycle load in LOAD, and the
//   winner's ack pulses in DONE. All outputs are registered.
//   Optional feature macro: REG_ARB_VERIFY_EN adds err_o/err_id_o, which flag
//   the first write whose read-back (reg_out_i) differs from the written data.
module register_write_arbiter #(
    parameter int N = 4,
    parameter int W = 16,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] wdata_i,
    output logic [N-1:0]   ack_o,
    output logic [N-1:0]   grant_o,
    output logic           busy_o,
    output logic [W-1:0]   reg_in_o,
    output logic           reg_load_o,
    input  logic [W-1:0]   reg_out_i
`ifdef REG_ARB_VERIFY_EN
    ,
    output logic           err_o,
    output logic [LW-1:0]  err_id_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [LW-1:0]   last_q;
    logic [LW-1:0]   sel_q;
    logic [W-1:0]    wr_data_q;
    logic [N-1:0]    ack_q;
    logic [N-1:0]    grant_q;
    logic            busy_q;
    logic [W-1:0]    reg_in_q;
    logic            reg_load_q;

    logic            found_d;
    logic [LW-1:0]   sel_d;
    logic [LW:0]     idx_s;
    logic [N-1:0]    onehot_d;
    logic [W-1:0]    wdata_sel_d;

`ifdef REG_ARB_VERIFY_EN
    logic            err_q;
    logic [LW-1:0]   err_id_q;
`else
    // Read-back is only consumed by the verify feature.
    logic            unused_reg_out_s;
    assign unused_reg_out_s = ^reg_out_i;
`endif

    // Round-robin pick: first asserted request scanning last+1, last+2, ... mod N.
    always_comb begin
        found_d = 1'b0;
        sel_d   = '0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = {1'b0, last_q} + (LW+1)'(k);
            if (idx_s >= (LW+1)'(N)) begin
                idx_s = idx_s - (LW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_d && req_i[idx_s[LW-1:0]]) begin
                found_d = 1'b1;
                sel_d   = idx_s[LW-1:0];
            end else begin
                found_d = found_d;
            end
        end
    end

    assign onehot_d    = {{(N-1){1'b0}}, 1'b1} << sel_d;
    assign wdata_sel_d = wdata_i[int'(sel_d)*W +: W];

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= LW'(N-1);
            sel_q      <= '0;
            wr_data_q  <= '0;
            ack_q      <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            reg_in_q   <= '0;
            reg_load_q <= 1'b0;
`ifdef REG_ARB_VERIFY_EN
            err_q      <= 1'b0;
            err_id_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= '0;
                    if (found_d) begin
                        state_q    <= ST_LOAD;
                        sel_q      <= sel_d;
                        wr_data_q  <= wdata_sel_d;
                        grant_q    <= onehot_d;
                        busy_q     <= 1'b1;
                        reg_in_q   <= wdata_sel_d;
                        reg_load_q <= 1'b1;
                    end else begin
                        state_q    <= ST_IDLE;
                        grant_q    <= '0;
                        busy_q     <= 1'b0;
                        reg_in_q   <= '0;
                        reg_load_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Register captured wr_data at this edge; report completion next.
                    state_q    <= ST_DONE;
                    reg_load_q <= 1'b0;
                    ack_q      <= grant_q;
                    last_q     <= sel_q;
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    ack_q      <= '0;
                    grant_q    <= '0;
                    busy_q     <= 1'b0;
                    reg_in_q   <= '0;
                    reg_load_q <= 1'b0;
`ifdef REG_ARB_VERIFY_EN
                    // Only the first failing write is recorded; the flag is sticky.
                    if (!err_q && (reg_out_i != wr_data_q)) begin
                        err_q    <= 1'b1;
                        err_id_q <= sel_q;
                    end else begin
                        err_q    <= err_q;
                        err_id_q <= err_id_q;
                    end
`endif
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ack_q      <= '0;
                    grant_q    <= '0;
                    busy_q     <= 1'b0;
                    reg_in_q   <= '0;
                    reg_load_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign reg_in_o   = reg_in_q;
    assign reg_load_o = reg_load_q;
`ifdef REG_ARB_VERIFY_EN
    assign err_o      = err_q;
    assign err_id_o   = err_id_q;
`endif

endmodule
